// File: rtl/eight_queen_pkg.sv
// -----------------------------------------------------------------------------
// eight_queen_pkg
// Shared types and helpers for the N-queens sequencing controller.
//   CW          : column/row index width (fixed at 3)
//   N_MIN/N_MAX : legal board-size range
//   QW          : width of the flat column stack (N_MAX rows of CW bits)
//   state_t     : controller FSM states
//   queen_at    : extract the column stored for one row of the flat stack
//   col_onehot  : one-hot column vector for an output beat
// -----------------------------------------------------------------------------
package eight_queen_pkg;

    localparam int CW    = 3;
    localparam int N_MIN = 4;
    localparam int N_MAX = 8;
    localparam int QW    = N_MAX * CW;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_BACKTRACK = 3'd2,
        S_EMIT      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // Row r lives in bits [CW*r+CW-1 : CW*r] of the flat stack.
    function automatic logic [CW-1:0] queen_at(input logic [QW-1:0] q,
                                               input logic [CW-1:0] row);
        return q[row*CW +: CW];
    endfunction

    function automatic logic [N_MAX-1:0] col_onehot(input logic [CW-1:0] col);
        logic [N_MAX-1:0] v;
        v      = '0;
        v[col] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/eight_queen_controller_if.sv
// -----------------------------------------------------------------------------
// eight_queen_controller_if
// Handshake, checker and output-stream signals of the N-queens controller.
//   start     : begin a search (host -> controller)
//   conflict  : combinational checker answer for (cand_row, cand_col)
//   ready     : controller idle
//   done      : one-cycle pulse at the end of a search
//   found     : a solution was streamed by the current/last search
//   cand_row  : row under test
//   cand_col  : column under test
//   queens    : flat placed-queen column stack, row r at [3r+2:3r]
//   out_valid : out_bus beat valid
//   out_bus   : one-hot column of the row being streamed
// master = controller side, slave = host/checker side.
// -----------------------------------------------------------------------------
interface eight_queen_controller_if;
    import eight_queen_pkg::*;

    logic              start;
    logic              conflict;
    logic              ready;
    logic              done;
    logic              found;
    logic [CW-1:0]     cand_row;
    logic [CW-1:0]     cand_col;
    logic [QW-1:0]     queens;
    logic              out_valid;
    logic [N_MAX-1:0]  out_bus;

    modport master (
        input  start, conflict,
        output ready, done, found, cand_row, cand_col, queens, out_valid, out_bus
    );

    modport slave (
        output start, conflict,
        input  ready, done, found, cand_row, cand_col, queens, out_valid, out_bus
    );

endinterface

// File: rtl/eight_queen_column_stack.sv
// -----------------------------------------------------------------------------
// eight_queen_column_stack
// N_MAX x CW register file holding the column of the queen placed in each row.
// One write port, flat read-out of all rows. Entries not being written keep
// their last value, so rows above the current search depth stay stable.
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset (clears all rows)
//   i_clear  : synchronous clear strobe (start of a new search)
//   i_we     : write enable
//   i_waddr  : row to write
//   i_wdata  : column value to write
//   o_q      : flat stack, row r at [CW*r+CW-1 : CW*r]
// -----------------------------------------------------------------------------
module eight_queen_column_stack
    import eight_queen_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_we,
    input  logic [CW-1:0] i_waddr,
    input  logic [CW-1:0] i_wdata,
    output logic [QW-1:0] o_q
);

    logic [N_MAX-1:0][CW-1:0] r_col;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_col <= '0;
        end else if (i_we) begin
            r_col[i_waddr] <= i_wdata;
        end
    end

    assign o_q = r_col;

endmodule

// File: rtl/eight_queen_controller.sv
// -----------------------------------------------------------------------------
// eight_queen_controller
// Depth-first backtracking N-queens sequencer. One candidate square is tested
// per cycle against an external combinational checker; on success the board
// is streamed one row per cycle as one-hot columns, followed by a done pulse.
//   N            : board size, legal range N_MIN..N_MAX
//   i_clk        : clock, rising edge
//   i_user_reset : synchronous active-low reset
//   bus          : eight_queen_controller_if.master (handshake, checker, stream)
// All outputs are registered except ready, which is decoded from the state.
// -----------------------------------------------------------------------------
module eight_queen_controller
    import eight_queen_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                       i_clk,
    input  logic                       i_user_reset,
    eight_queen_controller_if.master   bus
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cand_row;
    logic [CW-1:0]     w_row_nxt;
    logic [CW-1:0]     r_cand_col;
    logic [CW-1:0]     w_col_nxt;
    logic [CW-1:0]     r_emit_idx;
    logic [CW-1:0]     w_idx_nxt;
    logic              r_found;
    logic              w_found_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_out_valid;
    logic              w_ov_nxt;
    logic [N_MAX-1:0]  r_out_bus;
    logic [N_MAX-1:0]  w_bus_nxt;

    logic              w_clear;
    logic              w_we;
    logic [QW-1:0]     w_queens;
    logic [CW-1:0]     w_prev_row;
    logic [CW-1:0]     w_prev_col;

    eight_queen_column_stack u_stack (
        .i_clk   (i_clk),
        .i_rst_n (i_user_reset),
        .i_clear (w_clear),
        .i_we    (w_we),
        .i_waddr (r_cand_row),
        .i_wdata (r_cand_col),
        .o_q     (w_queens)
    );

    // Row we return to when the current row runs out of columns.
    assign w_prev_row = r_cand_row - 1'b1;
    assign w_prev_col = queen_at(w_queens, w_prev_row);

    always_ff @(posedge i_clk) begin
        if (!i_user_reset) begin
            r_state     <= S_IDLE;
            r_cand_row  <= '0;
            r_cand_col  <= '0;
            r_emit_idx  <= '0;
            r_found     <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_bus   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand_row  <= w_row_nxt;
            r_cand_col  <= w_col_nxt;
            r_emit_idx  <= w_idx_nxt;
            r_found     <= w_found_nxt;
            r_done      <= w_done_nxt;
            r_out_valid <= w_ov_nxt;
            r_out_bus   <= w_bus_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_cand_row;
        w_col_nxt   = r_cand_col;
        w_idx_nxt   = r_emit_idx;
        w_found_nxt = r_found;
        // done/out_valid/out_bus are pulses: zero unless a state asserts them,
        // which also keeps out_bus at 0 whenever out_valid is low.
        w_done_nxt  = 1'b0;
        w_ov_nxt    = 1'b0;
        w_bus_nxt   = '0;
        w_clear     = 1'b0;
        w_we        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_clear     = 1'b1;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_found_nxt = 1'b0;
                    w_state_nxt = S_CHECK;
                end
            end

            S_CHECK: begin
                if (!bus.conflict) begin
                    w_we = 1'b1;
                    if (r_cand_row == LAST) begin
                        // Row 0 was placed long ago, so beat 0 can be launched
                        // on the same edge that places the last queen.
                        w_idx_nxt   = '0;
                        w_ov_nxt    = 1'b1;
                        w_bus_nxt   = col_onehot(queen_at(w_queens, '0));
                        w_found_nxt = 1'b1;
                        w_state_nxt = S_EMIT;
                    end else begin
                        w_row_nxt = r_cand_row + 1'b1;
                        w_col_nxt = '0;
                    end
                end else if (r_cand_col < LAST) begin
                    w_col_nxt = r_cand_col + 1'b1;
                end else begin
                    w_state_nxt = S_BACKTRACK;
                end
            end

            S_BACKTRACK: begin
                if (r_cand_row == '0) begin
                    // Unreachable for legal N; ends the search without a result.
                    w_found_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_row_nxt = w_prev_row;
                    if (w_prev_col != LAST) begin
                        w_col_nxt   = w_prev_col + 1'b1;
                        w_state_nxt = S_CHECK;
                    end
                end
            end

            S_EMIT: begin
                if (r_emit_idx == LAST) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt = r_emit_idx + 1'b1;
                    w_ov_nxt  = 1'b1;
                    w_bus_nxt = col_onehot(queen_at(w_queens, r_emit_idx + 1'b1));
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.ready     = (r_state == S_IDLE);
    assign bus.done      = r_done;
    assign bus.found     = r_found;
    assign bus.cand_row  = r_cand_row;
    assign bus.cand_col  = r_cand_col;
    assign bus.queens    = w_queens;
    assign bus.out_valid = r_out_valid;
    assign bus.out_bus   = r_out_bus;

endmodule
